// File: rtl/exc_commit_pkg.sv
// exc_commit_pkg: ExcCodes, m_exc bit indices and commit FSM states shared by exc_commit and exc_prio
package exc_commit_pkg;
  localparam logic [5:0] EXC_INT  = 6'd0;
  localparam logic [5:0] EXC_ADEL = 6'd4;
  localparam logic [5:0] EXC_ADES = 6'd5;
  localparam logic [5:0] EXC_SYS  = 6'd8;
  localparam logic [5:0] EXC_BP   = 6'd9;
  localparam logic [5:0] EXC_RI   = 6'd10;
  localparam logic [5:0] EXC_OV   = 6'd12;
  typedef enum logic [2:0] {
    EB_ADES_D  = 3'd0,
    EB_ADEL_D  = 3'd1,
    EB_BP      = 3'd2,
    EB_SYS     = 3'd3,
    EB_OV      = 3'd4,
    EB_RI      = 3'd5,
    EB_ADEL_IF = 3'd6
  } exc_bit_e;
  typedef enum logic {IDLE, REDIRECT} state_e;
endpackage

// File: rtl/exc_commit_if.sv
// exc_commit_if: M-stage/CP0/fetch-redirect bundle; slave = exc_commit, master = pipeline side
interface exc_commit_if;
  logic        m_valid;
  logic        m_stall;
  logic [31:0] m_pc;
  logic        m_in_delay_slot;
  logic [6:0]  m_exc;
  logic [31:0] m_badaddr_d;
  logic        m_is_eret;
  logic        interrupt;
  logic [31:0] cp0_epc;
  logic        exception;
  logic [5:0]  m_excCode;
  logic        isBadAddr;
  logic [31:0] invalid_addr;
  logic [31:0] excPC;
  logic        inDelaySlot;
  logic        ERET2pc;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  modport master (
    output m_valid, m_stall, m_pc, m_in_delay_slot, m_exc, m_badaddr_d, m_is_eret,
           interrupt, cp0_epc, redirect_ready,
    input  exception, m_excCode, isBadAddr, invalid_addr, excPC, inDelaySlot, ERET2pc,
           flush, redirect_valid, redirect_pc
  );
  modport slave (
    input  m_valid, m_stall, m_pc, m_in_delay_slot, m_exc, m_badaddr_d, m_is_eret,
           interrupt, cp0_epc, redirect_ready,
    output exception, m_excCode, isBadAddr, invalid_addr, excPC, inDelaySlot, ERET2pc,
           flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exc_commit_prio.sv
// exc_prio: interrupt/m_exc -> any, highest-priority ExcCode, bad-address flags (interrupt, adel_if, ri, ov, sys, bp, adel_d, ades_d)
module exc_prio
  import exc_commit_pkg::*;
(
  input  logic       interrupt,
  input  logic [6:0] m_exc,
  output logic       any,
  output logic [5:0] code,
  output logic       is_badaddr,
  output logic       use_pc_as_bad
);
  always_comb begin
    any = interrupt | (|m_exc);
    code = interrupt              ? EXC_INT  :
           m_exc[EB_ADEL_IF]      ? EXC_ADEL :
           m_exc[EB_RI]           ? EXC_RI   :
           m_exc[EB_OV]           ? EXC_OV   :
           m_exc[EB_SYS]          ? EXC_SYS  :
           m_exc[EB_BP]           ? EXC_BP   :
           m_exc[EB_ADEL_D]       ? EXC_ADEL :
           m_exc[EB_ADES_D]       ? EXC_ADES : EXC_INT;
    is_badaddr = (code == EXC_ADEL) | (code == EXC_ADES);
    use_pc_as_bad = ~interrupt & m_exc[EB_ADEL_IF];
  end
endmodule

// File: rtl/exc_commit.sv
// exc_commit: M-stage commit of exceptions/ERET to CP0 plus held fetch redirect; ports clk, resetn (sync, active-low), bus (exc_commit_if.slave)
module exc_commit
  import exc_commit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input logic         clk,
  input logic         resetn,
  exc_commit_if.slave bus
);
  state_e      state, state_nx;
  logic        any, is_bad, use_pc, commit, ev_exc, ev_eret;
  logic [5:0]  code;
  logic [31:0] rpc;
  exc_prio u_prio (
    .interrupt     (bus.interrupt),
    .m_exc         (bus.m_exc),
    .any           (any),
    .code          (code),
    .is_badaddr    (is_bad),
    .use_pc_as_bad (use_pc)
  );
  always_ff @(posedge clk) begin
    state <= !resetn ? IDLE : state_nx;
    rpc <= !resetn ? '0 : ev_exc ? EXC_VECTOR : ev_eret ? bus.cp0_epc : rpc;
  end
  // resetn gates commit so no pulse escapes while reset is held
  always_comb begin
    commit = resetn & (state == IDLE) & bus.m_valid & ~bus.m_stall;
    ev_exc = commit & any;
    ev_eret = commit & bus.m_is_eret & ~any;
    state_nx = (state == IDLE) ? ((ev_exc | ev_eret) ? REDIRECT : IDLE)
                               : (bus.redirect_ready ? IDLE : REDIRECT);
  end
  always_comb begin
    bus.exception = ev_exc;
    bus.m_excCode = ev_exc ? code : 6'd0;
    bus.isBadAddr = ev_exc & is_bad;
    bus.invalid_addr = (ev_exc & is_bad) ? (use_pc ? bus.m_pc : bus.m_badaddr_d) : 32'd0;
    bus.excPC = ev_exc ? bus.m_pc : 32'd0;
    bus.inDelaySlot = ev_exc & bus.m_in_delay_slot;
    bus.ERET2pc = ev_eret;
    bus.flush = ev_exc | ev_eret | (state == REDIRECT);
    bus.redirect_valid = state == REDIRECT;
    bus.redirect_pc = rpc;
  end
  a_excl: assert property (@(posedge clk) disable iff (!resetn) !(bus.exception && bus.ERET2pc));
  a_idle: assert property (@(posedge clk) disable iff (!resetn) (state != IDLE) |-> !(bus.exception || bus.ERET2pc));
endmodule
